// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Oversamples the line CLKS_PER_BIT times per bit
// and samples each bit at its centre; holds one received byte with ack handshake.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx,
    input  logic       rx_ack,
    output logic [7:0] databus_write,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
    localparam logic [TimerW-1:0] HalfMax = TimerW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TimerW-1:0] FullMax = TimerW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    logic              r_rx_meta;
    logic              r_rx_s;
    state_e            r_state;
    state_e            w_state_nxt;
    logic [TimerW-1:0] r_timer;
    logic [TimerW-1:0] w_timer_nxt;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic [7:0]        r_data;
    logic [7:0]        w_data_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_ferr;
    logic              w_ferr_nxt;
    logic              r_overrun;
    logic              w_overrun_nxt;
    logic              w_load;
    logic              w_ack;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= Rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_load        = 1'b0;
        w_ferr_nxt    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (!r_rx_s) begin
                    w_state_nxt = StStart;
                    w_timer_nxt = '0;
                end
            end

            // Half a bit in: confirm the start bit is still low at its centre.
            StStart: begin
                if (r_timer == HalfMax) begin
                    w_timer_nxt   = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = r_rx_s ? StIdle : StData;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end

            StData: begin
                if (r_timer == FullMax) begin
                    w_timer_nxt            = '0;
                    w_shift_nxt[r_bit_idx] = r_rx_s;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = StStop;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end

            StStop: begin
                if (r_timer == FullMax) begin
                    w_timer_nxt = '0;
                    if (r_rx_s) begin
                        w_load      = 1'b1;
                        w_state_nxt = StIdle;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = StWaitIdle;
                    end
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end

            // Hold off until the line is released so a break is not seen as a start bit.
            StWaitIdle: begin
                if (r_rx_s) begin
                    w_state_nxt = StIdle;
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Ack only has meaning while a byte is held; a simultaneous load keeps valid set.
    assign w_ack = rx_ack && r_valid;

    always_comb begin
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_overrun_nxt = r_overrun;
        if (w_load) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
        end else if (w_ack) begin
            w_valid_nxt = 1'b0;
        end
        if (w_ack) begin
            w_overrun_nxt = 1'b0;
        end else if (w_load && r_valid) begin
            w_overrun_nxt = 1'b1;
        end
    end

    assign databus_write = r_data;
    assign rx_valid      = r_valid;
    assign frame_err     = r_ferr;
    assign overrun       = r_overrun;
    assign busy          = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected bytes/cycles,
// an independent monitor pops and compares whenever the DUT delivers.
module tb_uart_rx;

    localparam int N   = 16;
    localparam int H   = N / 2;
    localparam int LAT = 2 + H + 9 * N;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] databus_write;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   ferr_q[$];
    int   ack_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    uart_rx #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Rx           (Rx),
        .rx_ack       (rx_ack),
        .databus_write(databus_write),
        .rx_valid     (rx_valid),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ack driver: raises rx_ack for the cycle ending at each scheduled edge number.
    always @(negedge clk) begin
        while (ack_q.size() > 0 && ack_q[0] <= cyc) void'(ack_q.pop_front());
        if (ack_q.size() > 0 && ack_q[0] == cyc + 1) begin
            rx_ack = 1'b1;
            void'(ack_q.pop_front());
        end else begin
            rx_ack = 1'b0;
        end
    end

    // Monitor: a delivery is valid rising, a load on an acking edge, or data replaced.
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always begin
        logic ack_e;
        logic rst_e;
        exp_t e;
        int   fc;
        @(posedge clk);
        ack_e = rx_ack;
        rst_e = reset;
        cyc   = cyc + 1;
        #1;
        if (!rst_e) begin
            if (rx_valid && (!prev_valid || ack_e || databus_write !== prev_data)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'h0, databus_write}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_data", {24'h0, databus_write}, {24'h0, e.data});
                    chk("byte_cycle", cyc, e.cyc);
                end
            end
            if (frame_err) begin
                if (ferr_q.size() == 0) begin
                    chk("unexpected_frame_err", cyc, 32'hFFFF_FFFF);
                end else begin
                    fc = ferr_q.pop_front();
                    chk("frame_err_cycle", cyc, fc);
                end
            end
        end
        prev_valid = rx_valid;
        prev_data  = databus_write;
    end

    // Called at a negedge; returns at the negedge just before the next frame slot.
    task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
        exp_t e;
        t0 = cyc + 1;
        if (stop) begin
            e.data = d;
            e.cyc  = t0 + LAT;
            exp_q.push_back(e);
        end else begin
            ferr_q.push_back(t0 + LAT);
        end
        Rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            Rx = d[i];
            repeat (N) @(negedge clk);
        end
        Rx = stop;
        repeat (N) @(negedge clk);
    endtask

    initial begin
        int t0;
        int t1;
        int waited;

        repeat (3) @(negedge clk);
        chk("rst_data", {24'h0, databus_write}, 32'h00);
        chk("rst_valid", {31'h0, rx_valid}, 32'h0);
        chk("rst_ferr", {31'h0, frame_err}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Ack with nothing held is ignored.
        ack_q.push_back(cyc + 2);
        repeat (3) @(negedge clk);
        chk("idle_ack_valid", {31'h0, rx_valid}, 32'h0);
        chk("idle_ack_overrun", {31'h0, overrun}, 32'h0);

        // 0xA5 good frame, then a single-cycle ack.
        send_frame(8'hA5, 1'b1, t0);
        chk("a5_valid", {31'h0, rx_valid}, 32'h1);
        chk("a5_data", {24'h0, databus_write}, 32'hA5);
        ack_q.push_back(cyc + 2);
        repeat (3) @(negedge clk);
        chk("a5_acked", {31'h0, rx_valid}, 32'h0);

        // False start: line low for 3 edges.
        Rx = 1'b0;
        repeat (3) @(negedge clk);
        chk("false_start_busy", {31'h0, busy}, 32'h1);
        Rx = 1'b1;
        repeat (H + 3) @(negedge clk);
        chk("false_start_idle", {31'h0, busy}, 32'h0);
        chk("false_start_valid", {31'h0, rx_valid}, 32'h0);
        repeat (10) @(negedge clk);

        // 0x3C with bad stop; line held low 40 cycles after the data bits.
        send_frame(8'h3C, 1'b0, t0);
        repeat (40 - N) @(negedge clk);
        chk("ferr_busy_held", {31'h0, busy}, 32'h1);
        chk("ferr_valid", {31'h0, rx_valid}, 32'h0);
        chk("ferr_data_kept", {24'h0, databus_write}, 32'hA5);
        Rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("ferr_busy_released", {31'h0, busy}, 32'h0);
        repeat (5) @(negedge clk);

        // Overrun: 0x11 then 0x22 without ack.
        send_frame(8'h11, 1'b1, t0);
        chk("ovr_first_clean", {31'h0, overrun}, 32'h0);
        send_frame(8'h22, 1'b1, t0);
        chk("ovr_data", {24'h0, databus_write}, 32'h22);
        chk("ovr_valid", {31'h0, rx_valid}, 32'h1);
        chk("ovr_flag", {31'h0, overrun}, 32'h1);
        ack_q.push_back(cyc + 2);
        repeat (3) @(negedge clk);
        chk("ovr_ack_valid", {31'h0, rx_valid}, 32'h0);
        chk("ovr_ack_flag", {31'h0, overrun}, 32'h0);
        repeat (5) @(negedge clk);

        // Back-to-back 0x00, 0xFF; 0x00 acked on the edge 0xFF's stop is sampled.
        ack_q.push_back(cyc + 1 + 10 * N + LAT);
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        chk("b2b_data", {24'h0, databus_write}, 32'hFF);
        chk("b2b_valid", {31'h0, rx_valid}, 32'h1);
        chk("b2b_overrun", {31'h0, overrun}, 32'h0);
        ack_q.push_back(cyc + 2);
        repeat (3) @(negedge clk);
        chk("b2b_acked", {31'h0, rx_valid}, 32'h0);
        chk("b2b_overrun_end", {31'h0, overrun}, 32'h0);

        // Reset during data bit 4 of 0xFF, then a clean 0x5A.
        Rx = 1'b0;
        repeat (N) @(negedge clk);
        Rx = 1'b1;
        repeat (4 * N) @(negedge clk);
        chk("midframe_busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6 * N) @(negedge clk);
        chk("midframe_valid", {31'h0, rx_valid}, 32'h0);
        chk("midframe_data", {24'h0, databus_write}, 32'h00);
        chk("midframe_busy_after", {31'h0, busy}, 32'h0);
        send_frame(8'h5A, 1'b1, t0);
        chk("post_rst_data", {24'h0, databus_write}, 32'h5A);
        chk("post_rst_valid", {31'h0, rx_valid}, 32'h1);
        ack_q.push_back(cyc + 2);
        repeat (3) @(negedge clk);

        waited = 0;
        while ((exp_q.size() != 0 || ferr_q.size() != 0) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk("pending_bytes", exp_q.size(), 32'h0);
        chk("pending_frame_errs", ferr_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; the value SHALL be even and >= 4.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 rx_ack  input  1  consumer acknowledges the held byte; sampled on clk.
REQ-007 databus_write  output  8  last correctly framed received byte.
REQ-008 rx_valid  output  1  level; databus_write holds an unacknowledged byte.
REQ-009 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-010 overrun  output  1  sticky; a byte was overwritten before being acknowledged.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 Rx SHALL pass through a 2-flop synchronizer initialised to 1; all logic SHALL use only the synchronized value rx_s.
REQ-013 States SHALL be IDLE, START, DATA, STOP and WAIT_IDLE; a bit-timer counter of width $clog2(CLKS_PER_BIT) and a 3-bit bit index SHALL be kept.
REQ-014 IDLE: when rx_s is 0, the block SHALL move to START and clear the timer.
REQ-015 START: the timer SHALL count to CLKS_PER_BIT/2-1, then sample rx_s; if 0, go to DATA with timer and bit index cleared; if 1, the event is a false start and the block SHALL return to IDLE with no output change.
REQ-016 DATA: every CLKS_PER_BIT cycles, rx_s SHALL be sampled into shift-register bit [index]; after index 7 the block SHALL move to STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles rx_s SHALL be sampled; if 1, the block SHALL load databus_write from the shift register, set rx_valid on the next cycle, and return to IDLE.
REQ-018 STOP with rx_s sampled 0: frame_err SHALL pulse for 1 cycle, databus_write and rx_valid SHALL be unchanged, and the block SHALL enter WAIT_IDLE.
REQ-019 WAIT_IDLE: the block SHALL stay until rx_s is 1, then go to IDLE; this prevents a break condition being taken as a start bit.
REQ-020 Latency: with the first Rx-low clock edge counted as edge 0, the stop bit SHALL be sampled at edge 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (154 for the default), and rx_valid SHALL be high after that edge.
REQ-021 Handshake: rx_valid SHALL clear on the clock edge where rx_ack is 1; rx_ack while rx_valid is 0 SHALL be ignored.
REQ-022 If a good stop bit and rx_ack occur on the same edge, the new byte SHALL load, rx_valid SHALL stay 1, and overrun SHALL NOT set.
REQ-023 If a good stop bit occurs while rx_valid is 1 and rx_ack is 0, databus_write SHALL take the new byte and overrun SHALL set.
REQ-024 overrun SHALL clear only on rx_ack or reset.
REQ-025 Back-to-back frames SHALL be accepted: a start edge detected in the cycle after the return to IDLE SHALL begin a new frame.

Reset
REQ-026 While reset is high, on clk: state SHALL be IDLE, the synchronizer flops SHALL be 1, timer, bit index and shift register SHALL be 0, databus_write SHALL be 8'h00, and rx_valid, frame_err, overrun and busy SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no rx_valid or frame_err; the first start bit after reset release SHALL be received cleanly.

Verification
REQ-028 Frame 0xA5 with good stop, default parameter -> rx_valid rises after edge 154, databus_write=8'hA5; rx_ack one cycle -> rx_valid=0.
REQ-029 Rx low for 3 cycles then high -> START aborts, no rx_valid, no frame_err, busy returns to 0 within CLKS_PER_BIT/2+3 cycles.
REQ-030 Frame 0x3C with stop bit 0 and line held low for 40 cycles -> single frame_err pulse, rx_valid=0, databus_write unchanged, busy held until the line goes high.
REQ-031 Frames 0x11 then 0x22 with no rx_ack -> databus_write=8'h22, rx_valid=1, overrun=1; rx_ack -> rx_valid=0 and overrun=0.
REQ-032 reset pulse during DATA bit 4 of 0xFF, then frame 0x5A -> no output from the first frame; databus_write=8'h5A, rx_valid=1.
REQ-033 Back-to-back 0x00 and 0xFF, each acked on the same edge its successor's stop bit is sampled -> both bytes delivered in order, overrun stays 0.
